// File: rtl/mem_pkg.sv
// Shared memory-stage types and sizing constants.
// Used by the store buffer and its match logic.
package mem_pkg;

    localparam int SB_DEPTH   = 4;
    localparam int SB_MAX_AGE = 8;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-first address match over the valid store buffer entries.
// Returns hit and the data of the youngest matching entry.
module sb_match
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [29:0]       waddr,
    output logic              hit,
    output logic [31:0]       data
);

    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count && entries[idx].waddr == waddr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory.
// Drains when the port is idle; forwards to hitting loads.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH   = SB_DEPTH,
    parameter int MAX_AGE = SB_MAX_AGE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                Address,
    input  logic [31:0]                Write_Data,
    input  logic                       Mem_Read,
    input  logic                       Mem_Write,
    output logic [31:0]                Read_Data,
    output logic                       stall,
    output logic [31:0]                Dm_Address,
    output logic [31:0]                Dm_Write_Data,
    output logic                       Dm_Mem_Read,
    output logic                       Dm_Mem_Write,
    input  logic [31:0]                Dm_Read_Data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MAX_AGE + 1);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [AW-1:0] age;
    logic [CW-1:0] count_next;
    logic [AW-1:0] age_next;

    logic        hit;
    logic [31:0] fwd_data;
    logic        is_load;
    logic        push;
    logic        force_drain;
    logic        miss;
    logic        drain;

    sb_match #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .waddr   (Address[31:2]),
        .hit     (hit),
        .data    (fwd_data)
    );

    assign empty = (count == '0);

    // Classify the cycle and steer the data-memory port.
    always_comb begin
        push        = Mem_Write;
        is_load     = Mem_Read && !Mem_Write;
        force_drain = is_load && !hit && !empty && (age == AW'(MAX_AGE));
        miss        = is_load && !hit && !force_drain;
        drain       = !empty && !miss && !rst;
        stall       = force_drain && !rst;

        Dm_Mem_Read   = miss;
        Dm_Mem_Write  = drain;
        Dm_Address    = '0;
        Dm_Write_Data = '0;
        if (miss) begin
            Dm_Address = Address;
        end else if (drain) begin
            Dm_Address    = {entries[head].waddr, 2'b00};
            Dm_Write_Data = entries[head].data;
        end

        Read_Data = '0;
        if (is_load && hit) begin
            Read_Data = fwd_data;
        end else if (miss) begin
            Read_Data = Dm_Read_Data;
        end
    end

    // Next occupancy and starvation age.
    always_comb begin
        count_next = count + CW'(push) - CW'(drain);
        age_next   = age;
        if (drain || count_next == '0) begin
            age_next = '0;
        end else if (!empty && age != AW'(MAX_AGE)) begin
            age_next = age + 1'b1;
        end
    end

    // FIFO storage, pointers, occupancy and age.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            age   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{waddr: Address[31:2], data: Write_Data};
                tail          <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count_next;
            age   <= age_next;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Data memory modelled as read data = ~address.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] Read_Data;
    logic        stall;
    logic [31:0] Dm_Address;
    logic [31:0] Dm_Write_Data;
    logic        Dm_Mem_Read;
    logic        Dm_Mem_Write;
    logic [31:0] Dm_Read_Data;
    logic [2:0]  count;
    logic        empty;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] wlog [$];

    store_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .Address       (Address),
        .Write_Data    (Write_Data),
        .Mem_Read      (Mem_Read),
        .Mem_Write     (Mem_Write),
        .Read_Data     (Read_Data),
        .stall         (stall),
        .Dm_Address    (Dm_Address),
        .Dm_Write_Data (Dm_Write_Data),
        .Dm_Mem_Read   (Dm_Mem_Read),
        .Dm_Mem_Write  (Dm_Mem_Write),
        .Dm_Read_Data  (Dm_Read_Data),
        .count         (count),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    assign Dm_Read_Data = ~Dm_Address;

    always @(posedge clk) begin
        if (Dm_Mem_Write) wlog.push_back(Dm_Address);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        Mem_Read   = rd;
        Mem_Write  = wr;
        Address    = a;
        Write_Data = d;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        Mem_Read = 0; Mem_Write = 0; Address = 0; Write_Data = 0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_dmw", 32'(Dm_Mem_Write), 0);
        check("rst_stall", 32'(stall), 0);
        tick();
        rst = 1'b0;

        // idle with empty buffer
        drive(0, 0, 32'h0, 32'h0);
        check("idle_rd", Read_Data, 0);
        check("idle_dmw", 32'(Dm_Mem_Write), 0);
        tick();

        // miss load on empty buffer
        drive(1, 0, 32'h300, 0);
        check("miss_dmr", 32'(Dm_Mem_Read), 1);
        check("miss_addr", Dm_Address, 32'h300);
        check("miss_rd", Read_Data, ~32'h300);
        tick();

        // single store
        drive(0, 1, 32'h7D0, 32'h5);
        check("st_dmw0", 32'(Dm_Mem_Write), 0);
        check("st_stall", 32'(stall), 0);
        tick();
        drive(0, 0, 0, 0);
        check("st_count1", 32'(count), 1);
        check("st_dmw", 32'(Dm_Mem_Write), 1);
        check("st_addr", Dm_Address, 32'h7D0);
        check("st_data", Dm_Write_Data, 32'h5);
        tick();
        drive(0, 0, 0, 0);
        check("st_count0", 32'(count), 0);
        check("st_empty", 32'(empty), 1);
        tick();

        // forwarding
        drive(0, 1, 32'h10, 32'h1);
        tick();
        drive(0, 1, 32'h10, 32'h2);
        check("fw_head_dmw", 32'(Dm_Mem_Write), 1);
        check("fw_head_data", Dm_Write_Data, 32'h1);
        tick();
        drive(1, 0, 32'h10, 0);
        check("fw_rd", Read_Data, 32'h2);
        check("fw_dmr", 32'(Dm_Mem_Read), 0);
        check("fw_dmw", 32'(Dm_Mem_Write), 1);
        check("fw_waddr", Dm_Address, 32'h10);
        check("fw_stall", 32'(stall), 0);
        tick();
        drive(0, 0, 0, 0);
        check("fw_empty", 32'(empty), 1);
        tick();

        // back-to-back stores, written in program order
        wlog.delete();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 32'(i * 4), 32'(32'h100 + i));
            check("full_stall", 32'(stall), 0);
            check("full_cnt", 32'(count <= 3'd4), 1);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        check("full_nw", 32'(wlog.size()), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++)
            check("full_order", wlog[i], 32'(i * 4));
        check("full_empty", 32'(empty), 1);

        // starvation
        drive(0, 1, 32'h20, 32'h9);
        tick();
        for (int c = 1; c <= 8; c++) begin
            drive(1, 0, 32'h100, 0);
            check("stv_dmr", 32'(Dm_Mem_Read), 1);
            check("stv_stall", 32'(stall), 0);
            check("stv_rd", Read_Data, ~32'h100);
            tick();
        end
        drive(1, 0, 32'h100, 0);
        check("stv9_stall", 32'(stall), 1);
        check("stv9_dmw", 32'(Dm_Mem_Write), 1);
        check("stv9_addr", Dm_Address, 32'h20);
        check("stv9_data", Dm_Write_Data, 32'h9);
        check("stv9_dmr", 32'(Dm_Mem_Read), 0);
        check("stv9_rd", Read_Data, 0);
        tick();
        drive(1, 0, 32'h100, 0);
        check("stv10_stall", 32'(stall), 0);
        check("stv10_dmr", 32'(Dm_Mem_Read), 1);
        check("stv10_rd", Read_Data, ~32'h100);
        check("stv10_empty", 32'(empty), 1);
        tick();

        // illegal read+write acts as store
        drive(1, 1, 32'h40, 32'h7);
        check("ill_rd", Read_Data, 0);
        check("ill_stall", 32'(stall), 0);
        check("ill_dmr", 32'(Dm_Mem_Read), 0);
        tick();
        drive(0, 0, 0, 0);
        check("ill_count", 32'(count), 1);
        check("ill_waddr", Dm_Address, 32'h40);
        tick();

        // reset with a pending store
        drive(0, 1, 32'h80, 32'hAA);
        tick();
        rst = 1'b1;
        #1;
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dmw", 32'(Dm_Mem_Write), 0);
        Mem_Write = 0;
        tick();
        rst = 1'b0;
        wlog.delete();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0);
            check("mrst_nodmw", 32'(Dm_Mem_Write), 0);
            tick();
        end
        check("mrst_nlog", 32'(wlog.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
